// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / data) for a single-port unified memory with a
// fixed one-cycle response pipeline. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h0100_0000,
  parameter int          MEM_WORDS = 262144
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int        STARVE_LIMIT = 4
`endif
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_address,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_error,

  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_write,
  input  logic [3:0]  d_req_strobe,
  input  logic [31:0] d_req_address,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_error,

  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [3:0]  mem_strobe,
  output logic [31:0] mem_data_in,
  output logic        mem_enable,
  input  logic [31:0] mem_data_out
);

  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

  tag_e        tag_q, tag_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;

  logic        if_grant;
  logic        d_grant;
  logic        starve_force;
  logic [31:0] sel_addr;
  logic [31:0] offset;
  logic        addr_err;
  logic        access;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0]  starve_q, starve_d;

  assign starve_force = (starve_q == 3'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!if_req_valid || if_grant) begin
      starve_d = 3'd0;
    end else if (!starve_force) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // No grants are issued while reset is held; anything accepted then would be dropped.
  always_comb begin
    if_grant = 1'b0;
    d_grant  = 1'b0;
    if (reset_n) begin
      if (d_req_valid && !(if_req_valid && starve_force)) begin
        d_grant = 1'b1;
      end else if (if_req_valid) begin
        if_grant = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = d_grant ? d_req_address : if_req_address;
    offset   = sel_addr - ADDR_BASE;
    addr_err = (sel_addr < ADDR_BASE) ||
               ({1'b0, sel_addr} >= ADDR_END) ||
               (sel_addr[1:0] != 2'b00);
    access   = (if_grant || d_grant) && !addr_err;
  end

  always_comb begin
    if_req_ready   = if_grant;
    d_req_ready    = d_grant;
    mem_enable     = access;
    mem_address    = access ? (offset >> 2) : 32'd0;
    mem_read_write = access && d_grant && d_req_write;
    mem_strobe     = mem_read_write ? d_req_strobe : 4'b0000;
    mem_data_in    = access ? d_req_wdata : 32'd0;
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (d_grant) begin
      tag_d = TAG_D;
    end else if (if_grant) begin
      tag_d = TAG_IF;
    end
    err_d = (if_grant || d_grant) && addr_err;
    wr_d  = d_grant && d_req_write;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= TAG_NONE;
      err_q <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      tag_q <= tag_d;
      err_q <= err_d;
      wr_q  <= wr_d;
    end
  end

  // Stores and erroring accesses return zero data; only clean loads/fetches pass array data.
  always_comb begin
    if_rsp_valid = (tag_q == TAG_IF);
    if_rsp_error = if_rsp_valid && err_q;
    if_rsp_data  = (if_rsp_valid && !err_q) ? mem_data_out : 32'd0;
    d_rsp_valid  = (tag_q == TAG_D);
    d_rsp_error  = d_rsp_valid && err_q;
    d_rsp_data   = (d_rsp_valid && !err_q && !wr_q) ? mem_data_out : 32'd0;
  end

endmodule
